// File: rtl/sat_arith_pkg.sv
// Shared definitions for the saturating arithmetic pipe: the op encodings
// and the signed saturation bounds for a given lane width.
package sat_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // Largest value representable in a signed lane of the given width.
    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed lane of the given width.
    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 32'd1));
    endfunction

endpackage : sat_arith_pkg

// File: rtl/sat_lane.sv
// One lane of the saturating unit: exact WIDTH+1-bit add/sub/accumulate
// followed by a clamp to the signed WIDTH-bit range.
module sat_lane
    import sat_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_res,
    output logic             o_ovf
);

    localparam logic signed [63:0]    MAX_64 = sat_max(WIDTH);
    localparam logic signed [63:0]    MIN_64 = sat_min(WIDTH);
    localparam logic signed [WIDTH:0] MAX_X  = MAX_64[WIDTH:0];
    localparam logic signed [WIDTH:0] MIN_X  = MIN_64[WIDTH:0];

    logic signed [WIDTH:0] w_a_x;
    logic signed [WIDTH:0] w_b_x;
    logic signed [WIDTH:0] w_acc_x;
    logic signed [WIDTH:0] w_sum;

    // One extra bit holds every exact result, including 0 - min = max + 1.
    assign w_a_x   = {i_a[WIDTH-1], i_a};
    assign w_b_x   = {i_b[WIDTH-1], i_b};
    assign w_acc_x = {i_acc[WIDTH-1], i_acc};

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        w_sum = '0;
        unique case (i_op)
            OP_ADD:  w_sum = w_a_x + w_b_x;
            OP_SUB:  w_sum = w_a_x - w_b_x;
            OP_ACC:  w_sum = w_acc_x + w_a_x;
            default: w_sum = '0;
        endcase
    end

    always_comb begin
        o_res = w_sum[WIDTH-1:0];
        o_ovf = 1'b0;
        if (w_sum > MAX_X) begin
            o_res = MAX_X[WIDTH-1:0];
            o_ovf = 1'b1;
        end else if (w_sum < MIN_X) begin
            o_res = MIN_X[WIDTH-1:0];
            o_ovf = 1'b1;
        end
    end

endmodule : sat_lane

// File: rtl/sat_arith_pipe.sv
// Two-stage, multi-lane saturating arithmetic pipe with per-lane accumulators,
// sticky overflow flags and valid/ready handshakes on both sides.
module sat_arith_pipe
    import sat_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic                   clr_sticky,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] res,
    output logic [LANES-1:0]       ovf,
    output logic [LANES-1:0]       sticky
);

    logic                   r_s1_valid;
    op_e                    r_s1_op;
    logic [LANES*WIDTH-1:0] r_s1_a;
    logic [LANES*WIDTH-1:0] r_s1_b;

    logic                   r_out_valid;
    logic [LANES*WIDTH-1:0] r_res;
    logic [LANES-1:0]       r_ovf;
    logic [LANES-1:0]       r_sticky;
    logic [WIDTH-1:0]       r_acc [LANES];

    logic                   w_advance;
    logic                   w_accept;
    logic [LANES*WIDTH-1:0] w_res;
    logic [LANES-1:0]       w_ovf;
    logic [LANES-1:0]       w_sticky_next;

    // S1 empties into S2 whenever S2 is empty or being drained this cycle.
    assign w_advance = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_advance;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign ovf       = r_ovf;
    assign sticky    = r_sticky;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        sat_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .i_op  (r_s1_op),
            .i_a   (r_s1_a[gi*WIDTH +: WIDTH]),
            .i_b   (r_s1_b[gi*WIDTH +: WIDTH]),
            .i_acc (r_acc[gi]),
            .o_res (w_res[gi*WIDTH +: WIDTH]),
            .o_ovf (w_ovf[gi])
        );
    end

    // A set from an overflowing advance beats a same-edge clr_sticky.
    always_comb begin
        w_sticky_next = clr_sticky ? '0 : r_sticky;
        if (w_advance) begin
            if (r_s1_op == OP_CLR) begin
                w_sticky_next = '0;
            end else begin
                w_sticky_next = w_sticky_next | w_ovf;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= op_e'(op);
            r_s1_a     <= a;
            r_s1_b     <= b;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_ovf       <= '0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res;
            r_ovf       <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= w_sticky_next;
        end
    end

    // NOTE: the accumulators are a few flops, not a RAM, so they take the reset like any other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_advance) begin
            for (int i = 0; i < LANES; i++) begin
                unique case (r_s1_op)
                    OP_ACC:  r_acc[i] <= w_res[i*WIDTH +: WIDTH];
                    OP_CLR:  r_acc[i] <= '0;
                    default: r_acc[i] <= r_acc[i];
                endcase
            end
        end
    end

endmodule : sat_arith_pipe

// File: tb/tb_sat_arith_pipe.sv
// Self-checking bench for sat_arith_pipe: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_sat_arith_pipe;
    import sat_arith_pkg::*;

    localparam int W    = 8;
    localparam int L    = 2;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     op;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic           clr_sticky;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] res;
    logic [L-1:0]   ovf;
    logic [L-1:0]   sticky;

    sat_arith_pipe #(.WIDTH(W), .LANES(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .clr_sticky (clr_sticky),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res        (res),
        .ovf        (ovf),
        .sticky     (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [L*W-1:0] pack(input int v0, input int v1);
        logic [31:0] t0;
        logic [31:0] t1;
        t0 = v0;
        t1 = v1;
        return {t1[W-1:0], t0[W-1:0]};
    endfunction

    function automatic int lane_val(input logic [L*W-1:0] v, input int i);
        logic signed [W-1:0] t;
        t = v[i*W +: W];
        return int'(t);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]     op;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
    } bundle_t;

    bundle_t        m_pend[$];
    bit             m_out_valid;
    logic [L*W-1:0] m_res;
    logic [L-1:0]   m_ovf;
    logic [L-1:0]   m_sticky;
    int             m_acc [L];
    bit             live = 1'b0;

    function automatic bit exp_in_ready();
        return (m_pend.size() == 0) || !m_out_valid || out_ready;
    endfunction

    always @(posedge clk) begin : model
        bit           adv;
        bit           take;
        bundle_t      bd;
        logic [L-1:0] base;
        int           x;
        int           r;
        logic [31:0]  rv;
        if (!rst_n) begin
            m_pend.delete();
            m_out_valid = 1'b0;
            m_res       = '0;
            m_ovf       = '0;
            m_sticky    = '0;
            for (int i = 0; i < L; i++) m_acc[i] = 0;
            live = 1'b1;
        end else if (live) begin
            adv  = (m_pend.size() > 0) && (!m_out_valid || out_ready);
            take = in_valid && exp_in_ready();
            base = clr_sticky ? '0 : m_sticky;
            if (adv) begin
                bd = m_pend.pop_front();
                for (int i = 0; i < L; i++) begin
                    case (bd.op)
                        2'b00:   x = lane_val(bd.a, i) + lane_val(bd.b, i);
                        2'b01:   x = lane_val(bd.a, i) - lane_val(bd.b, i);
                        2'b10:   x = m_acc[i] + lane_val(bd.a, i);
                        default: x = 0;
                    endcase
                    if (x > MAXV) begin
                        r = MAXV; m_ovf[i] = 1'b1;
                    end else if (x < MINV) begin
                        r = MINV; m_ovf[i] = 1'b1;
                    end else begin
                        r = x; m_ovf[i] = 1'b0;
                    end
                    rv = r;
                    m_res[i*W +: W] = rv[W-1:0];
                    if (bd.op == 2'b10) m_acc[i] = r;
                    if (bd.op == 2'b11) m_acc[i] = 0;
                end
                m_out_valid = 1'b1;
                m_sticky    = (bd.op == 2'b11) ? '0 : (base | m_ovf);
            end else begin
                if (out_ready) m_out_valid = 1'b0;
                m_sticky = base;
            end
            if (take) m_pend.push_back('{op: op, a: a, b: b});
        end
    end

    always @(negedge clk) begin
        if (live && rst_n) begin
            check("in_ready", in_ready, exp_in_ready());
            check("out_valid", out_valid, m_out_valid);
            check("res", res, m_res);
            check("ovf", ovf, m_ovf);
            check("sticky", sticky, m_sticky);
        end
    end

    // Results actually consumed by the downstream side, in arrival order.
    logic [L*W-1:0] log_res[$];
    logic [L-1:0]   log_ovf[$];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            log_res.push_back(res);
            log_ovf.push_back(ovf);
        end
    end

    task automatic check_log(input string name, input int idx, input int r0, input int r1,
                             input logic [L-1:0] o);
        check({name, "_present"}, log_res.size() > idx, 1);
        if (log_res.size() > idx) begin
            check({name, "_res"}, log_res[idx], pack(r0, r1));
            check({name, "_ovf"}, log_ovf[idx], o);
        end
    endtask

    // Tasks start just after a rising edge and return just after one.
    task automatic send(input logic [1:0] o, input int a0, input int a1, input int b0, input int b1);
        bit accepted;
        accepted = 1'b0;
        #1;
        in_valid = 1'b1;
        op       = o;
        a        = pack(a0, a1);
        b        = pack(b0, b1);
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
        end
        check("send_accepted", accepted, 1);
    endtask

    task automatic idle(input int n);
        #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    function automatic int rnd_lane();
        case ($urandom_range(0, 5))
            0:       return MAXV;
            1:       return MINV;
            2:       return -1;
            3:       return 0;
            default: return int'($urandom_range(0, 2 * MAXV + 1)) + MINV;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op         = 2'b00;
        a          = '0;
        b          = '0;
        clr_sticky = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sticky", sticky, 0);
        check("rst_res", res, 0);
        @(posedge clk);

        // Basic ADD and two-cycle latency
        send(OP_ADD, 100, -50, 27, -20);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("add_res", res, pack(127, -70));
        check("add_ovf", ovf, 2'b00);
        @(posedge clk);

        // Saturation corners
        log_res.delete(); log_ovf.delete();
        send(OP_ADD, 100, 1, 100, 2);
        send(OP_SUB, -100, 0, 100, -128);
        send(OP_SUB, -1, 5, -128, 7);
        idle(4);
        check_log("sat0", 0, 127, 3, 2'b01);
        check_log("sat1", 1, -128, 127, 2'b11);
        check_log("sat2", 2, 127, -2, 2'b00);
        check("sat_sticky", sticky, 2'b11);

        // Sticky priority: set wins over a same-edge clear
        send(OP_ADD, 100, 0, 100, 0);
        #1 in_valid = 1'b0; clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_set_wins", sticky, 2'b01);
        @(posedge clk);
        #1 clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_clr", sticky, 2'b00);
        @(posedge clk);

        // Accumulate chain
        log_res.delete(); log_ovf.delete();
        send(OP_CLR, 0, 0, 0, 0);
        repeat (3) send(OP_ACC, 60, -60, 0, 0);
        send(OP_ACC, -100, 100, 0, 0);
        idle(4);
        check_log("acc_clr", 0, 0, 0, 2'b00);
        check_log("acc1", 1, 60, -60, 2'b00);
        check_log("acc2", 2, 120, -120, 2'b00);
        check_log("acc3", 3, 127, -128, 2'b11);
        check_log("acc4", 4, 27, -28, 2'b00);
        check("acc_sticky", sticky, 2'b11);
        send(OP_CLR, 9, 9, 9, 9);
        idle(3);
        check("clr_op_sticky", sticky, 2'b00);
        check("clr_op_res", res, 0);

        // Backpressure: two accepted, then stall
        log_res.delete(); log_ovf.delete();
        #1 out_ready = 1'b0;
        send(OP_ADD, 1, -1, 10, -10);
        send(OP_ADD, 2, -2, 20, -20);
        #1;
        in_valid = 1'b1; op = OP_ADD; a = pack(3, -3); b = pack(30, -30);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_res_hold", res, pack(11, -11));
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        send(OP_ADD, 3, -3, 30, -30);
        send(OP_ADD, 4, -4, 40, -40);
        idle(5);
        check("bp_count", log_res.size(), 4);
        check_log("bp0", 0, 11, -11, 2'b00);
        check_log("bp1", 1, 22, -22, 2'b00);
        check_log("bp2", 2, 33, -33, 2'b00);
        check_log("bp3", 3, 44, -44, 2'b00);

        // Reset with both stages full
        send(OP_ACC, 7, -7, 0, 0);
        idle(2);
        log_res.delete(); log_ovf.delete();
        #1 out_ready = 1'b0;
        send(OP_ADD, 1, 1, 1, 1);
        send(OP_ADD, 2, 2, 2, 2);
        #1 in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_res", res, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(OP_ACC, 5, 5, 0, 0);
        idle(4);
        check("mid_rst_count", log_res.size(), 1);
        check_log("mid_rst_acc", 0, 5, 5, 2'b00);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            #1;
            in_valid   = ($urandom_range(0, 3) != 0);
            op         = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a          = pack(rnd_lane(), rnd_lane());
            b          = pack(rnd_lane(), rnd_lane());
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 15) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1; in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sat_arith_pipe
